step_chunker: RTL and testbench

- Command sequencer directly upstream of the stepper_motor pulse generator.
- Accepts a signed 16-bit relative move and splits it into chunks of at most MAX_CHUNK steps, because the motor stage must never receive more than 99 steps.
- Issues one new_in pulse per chunk and waits for that stage's finished flag before sending the next chunk.
- Reports busy, remaining steps and a completion pulse to the trajectory/control logic above it.

---
 rtl/step_chunker_if.sv | 53 +++++
 rtl/step_chunker.sv | 199 +++++++++++++++++++
 tb/tb_step_chunker.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_chunker_if.sv
// step_chunker_if -- command and motor-stage bundle for step_chunker.
//
// Groups the upstream command handshake, the status reported back to the
// trajectory logic and the chunk interface to the stepper_motor stage.
//   slave  : the chunker itself (takes commands, drives the motor stage)
//   master : the surrounding environment (issues commands, models the motor)
//
// Optional: STEP_CHUNKER_POSITION_TRACK_EN adds position / pos_clear.
interface step_chunker_if;
    // command side
    logic               cmd_valid;
    logic               cmd_ready;
    logic [15:0]        cmd_steps;
    logic               cmd_fast;
    logic               abort;
    // motor-stage side
    logic               new_in;
    logic [7:0]         num_steps;
    logic               fast;
    logic               direction;
    logic               finished;
    // status
    logic               busy;
    logic               done;
    logic               aborted;
    logic [15:0]        steps_remaining;
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
    logic signed [31:0] position;
    logic               pos_clear;

    modport slave (
        input  cmd_valid, cmd_steps, cmd_fast, abort, finished, pos_clear,
        output cmd_ready, new_in, num_steps, fast, direction,
               busy, done, aborted, steps_remaining, position
    );
    modport master (
        output cmd_valid, cmd_steps, cmd_fast, abort, finished, pos_clear,
        input  cmd_ready, new_in, num_steps, fast, direction,
               busy, done, aborted, steps_remaining, position
    );
`else
    modport slave (
        input  cmd_valid, cmd_steps, cmd_fast, abort, finished,
        output cmd_ready, new_in, num_steps, fast, direction,
               busy, done, aborted, steps_remaining
    );
    modport master (
        output cmd_valid, cmd_steps, cmd_fast, abort, finished,
        input  cmd_ready, new_in, num_steps, fast, direction,
               busy, done, aborted, steps_remaining
    );
`endif
endinterface

// File: rtl/step_chunker.sv
// step_chunker -- splits a signed 16-bit relative move into chunks of at
// most MAX_CHUNK steps for the stepper_motor pulse generator, one new_in
// strobe per chunk, waiting for the stage's finished flag in between.
//
// Ports:
//   clk_50   in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave side of step_chunker_if:
//            cmd_valid/cmd_ready/cmd_steps/cmd_fast  command handshake
//            abort                                   drop untransmitted steps
//            new_in/num_steps/fast/direction         chunk to motor stage
//            finished                                motor stage chunk complete
//            busy/done/aborted/steps_remaining       status upward
//
// Optional feature macro: STEP_CHUNKER_POSITION_TRACK_EN
//   adds bus.position (signed running total of completed chunks) and
//   bus.pos_clear (zeroes position, honoured only while idle).
module step_chunker #(
    parameter int MAX_CHUNK     = 99,  // 1..99
    parameter int PULSE_CYCLES  = 4,   // >= 2
    parameter int SETTLE_CYCLES = 8    // >= 2
) (
    input  logic clk_50,
    input  logic reset_n,
    step_chunker_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [15:0] MAX16      = 16'(MAX_CHUNK);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] steps_rem;
    logic [7:0]  num_steps_q;
    logic        fast_q;
    logic        direction_q;
    logic        new_in_q;
    logic        busy_q;
    logic        ready_q;
    logic        done_q;
    logic        aborted_q;
    logic        abort_flag;

    logic [15:0] mag;
    logic [15:0] chunk;
    logic        accept;
    logic        abort_any;

    // Two's-complement magnitude; -32768 wraps to 16'h8000 which reads
    // correctly as 32768 unsigned.
    assign mag       = bus.cmd_steps[15] ? (~bus.cmd_steps + 16'd1) : bus.cmd_steps;
    assign chunk     = (steps_rem > MAX16) ? MAX16 : steps_rem;
    assign accept    = bus.cmd_valid && ready_q;
    // Abort seen this cycle counts the same as one latched earlier.
    assign abort_any = abort_flag || bus.abort;

`ifdef STEP_CHUNKER_POSITION_TRACK_EN
    logic signed [31:0] pos_q;
    logic signed [31:0] chunk_signed;

    assign chunk_signed = $signed({24'd0, num_steps_q});
    assign bus.position = pos_q;
`endif

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            steps_rem   <= '0;
            num_steps_q <= '0;
            fast_q      <= 1'b0;
            direction_q <= 1'b0;
            new_in_q    <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            abort_flag  <= 1'b0;
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
            pos_q       <= '0;
`endif
        end else begin
            // Abort is sticky for the rest of the move and discards whatever
            // has not been handed to the motor stage yet. The LOAD branch
            // below overrides steps_rem explicitly with the same result.
            if ((state inside {S_LOAD, S_PULSE, S_SETTLE, S_WAIT}) && bus.abort) begin
                abort_flag <= 1'b1;
                steps_rem  <= '0;
            end

            case (state)
                S_IDLE: begin
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
                    if (bus.pos_clear)
                        pos_q <= '0;
`endif
                    if (accept) begin
                        steps_rem   <= mag;
                        direction_q <= bus.cmd_steps[15];
                        fast_q      <= bus.cmd_fast;
                        abort_flag  <= 1'b0;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        state       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // A zero-length move also passes through here so it
                    // reports busy for two cycles like any other move start.
                    if (steps_rem == 16'd0) begin
                        done_q    <= 1'b1;
                        aborted_q <= abort_any;
                        state     <= S_DONE;
                    end else begin
                        assert (chunk <= steps_rem && chunk[15:8] == 8'd0);
                        num_steps_q <= chunk[7:0];
                        steps_rem   <= abort_any ? 16'd0 : steps_rem - chunk;
                        new_in_q    <= 1'b1;
                        cnt         <= '0;
                        state       <= S_PULSE;
                    end
                end

                S_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        new_in_q <= 1'b0;
                        cnt      <= '0;
                        state    <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // finished may still be high from the previous chunk; give
                // the motor stage time to drop it before it is trusted.
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // No timeout: a motor stage that never finishes needs reset.
                S_WAIT: begin
                    if (bus.finished) begin
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
                        pos_q <= direction_q ? (pos_q - chunk_signed)
                                             : (pos_q + chunk_signed);
`endif
                        if (steps_rem != 16'd0 && !abort_any) begin
                            state <= S_LOAD;
                        end else begin
                            done_q    <= 1'b1;
                            aborted_q <= abort_any;
                            state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    done_q     <= 1'b0;
                    aborted_q  <= 1'b0;
                    abort_flag <= 1'b0;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b1;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready       = ready_q;
    assign bus.new_in          = new_in_q;
    assign bus.num_steps       = num_steps_q;
    assign bus.fast            = fast_q;
    assign bus.direction       = direction_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.aborted         = aborted_q;
    assign bus.steps_remaining = steps_rem;

endmodule

// File: tb/tb_step_chunker.sv
// Bench for step_chunker: directed moves against a chunk-list model plus a
// motor-stage model that raises finished a fixed delay after new_in falls.
module tb_step_chunker;

    localparam int P     = 4;
    localparam int S     = 8;
    localparam int MAXC  = 99;
    localparam int MOTOR_DELAY = 20;

    logic clk_50  = 1'b0;
    logic reset_n = 1'b0;

    step_chunker_if bus ();

    step_chunker #(.MAX_CHUNK(MAXC), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk_50 = ~clk_50;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    int  exp_q[$];      // chunks still expected for the current move
    int  obs_steps[$];  // observed num_steps per chunk
    int  obs_rem[$];    // observed steps_remaining per chunk
    int  exp_mag, sent_sum, exp_pos;
    bit  exp_dir, exp_fast, exp_aborted;
    bit  stale = 1'b0;
    int  n_rise = 0, done_cnt = 0;
    int  cyc = 0, last_rise = 0, width = 0, hold = 0;
    bit  have_rise = 1'b0, prev_ni = 1'b0;

    // ---------------- motor stage model ----------------
    int mcnt = 0;
    bit m_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk_50);
            if (stale) begin
                bus.finished = 1'b1;
            end else begin
                if (bus.new_in && !m_prev) bus.finished = 1'b0;
                if (!bus.new_in && m_prev) mcnt = MOTOR_DELAY;
                else if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) bus.finished = 1'b1;
                end
            end
            m_prev = bus.new_in;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk_50) begin
        if (!reset_n) begin
            prev_ni = 1'b0;
            width   = 0;
        end else begin
            cyc++;
            chk("ready_vs_busy", int'(bus.cmd_ready), int'(!bus.busy));
            if (!bus.busy) chk("idle_new_in", int'(bus.new_in), 0);
            if (bus.new_in && !prev_ni) begin
                n_rise++;
                obs_steps.push_back(int'(bus.num_steps));
                obs_rem.push_back(int'(bus.steps_remaining));
                chk("chunk_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    int e;
                    e = exp_q.pop_front();
                    sent_sum += e;
                    exp_pos  += exp_dir ? -e : e;
                    chk("num_steps", int'(bus.num_steps), e);
                    chk("steps_remaining", int'(bus.steps_remaining), exp_mag - sent_sum);
                end
                chk("direction", int'(bus.direction), int'(exp_dir));
                chk("fast", int'(bus.fast), int'(exp_fast));
                if (have_rise) begin
                    if (stale) chk("gap_exact", cyc - last_rise, P + S + 2);
                    else       chk("gap_min", int'(cyc - last_rise >= P + S + 2), 1);
                end
                have_rise = 1'b1;
                last_rise = cyc;
                hold      = int'(bus.num_steps);
                width     = 1;
            end else if (bus.new_in) begin
                width++;
            end else if (prev_ni) begin
                chk("pulse_width", width, P);
            end
            if (bus.busy && have_rise) chk("steps_stable", int'(bus.num_steps), hold);
            if (bus.done) begin
                done_cnt++;
                chk("aborted", int'(bus.aborted), int'(exp_aborted));
                chk("chunks_left", exp_q.size(), 0);
                chk("rem_at_done", int'(bus.steps_remaining), 0);
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
                chk("position", int'(bus.position), exp_pos);
`endif
            end
            prev_ni = bus.new_in;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk_50);
        #1;
    endtask

    task automatic send(input int steps, input bit f, input int keep, input bit ab);
        int r, t;
        r = (steps < 0) ? -steps : steps;
        exp_q.delete();
        obs_steps.delete();
        obs_rem.delete();
        exp_mag = r;
        while (r > 0) begin
            int c;
            c = (r > MAXC) ? MAXC : r;
            exp_q.push_back(c);
            r -= c;
        end
        while (keep >= 0 && exp_q.size() > keep) void'(exp_q.pop_back());
        exp_dir     = (steps < 0);
        exp_fast    = f;
        exp_aborted = ab;
        sent_sum    = 0;
        have_rise   = 1'b0;
        t = 0;
        tick();
        while (!bus.cmd_ready && t < 200) begin
            tick();
            t++;
        end
        chk("ready_timeout", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = 16'(steps);
        bus.cmd_fast  = f;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int st, t;
        st = done_cnt;
        t  = 0;
        while (done_cnt == st && t < budget) begin
            tick();
            t++;
        end
        chk("done_timeout", int'(done_cnt != st), 1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int t;
        t = 0;
        while (n_rise < target && t < budget) begin
            tick();
            t++;
        end
        chk("rise_timeout", int'(n_rise >= target), 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
        chk({tag, "_new_in"}, int'(bus.new_in), 0);
        chk({tag, "_num_steps"}, int'(bus.num_steps), 0);
        chk({tag, "_fast"}, int'(bus.fast), 0);
        chk({tag, "_direction"}, int'(bus.direction), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_aborted"}, int'(bus.aborted), 0);
        chk({tag, "_steps_remaining"}, int'(bus.steps_remaining), 0);
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
        chk({tag, "_position"}, int'(bus.position), 0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        bus.cmd_valid = 1'b0;
        bus.cmd_steps = '0;
        bus.cmd_fast  = 1'b0;
        bus.abort     = 1'b0;
        bus.finished  = 1'b0;
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
        bus.pos_clear = 1'b0;
`endif
        exp_pos = 0;

        // reset state
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;

        // -5, fast: one chunk of 5, reverse
        send(-5, 1'b1, -1, 1'b0);
        wait_done(500);
        chk("m5_chunks", obs_steps.size(), 1);
        chk("m5_steps", obs_steps[0], 5);
        chk("m5_direction", int'(bus.direction), 1);
        chk("m5_fast", int'(bus.fast), 1);
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
        chk("m5_position", int'(bus.position), -5);
`endif

        // 250: 99, 99, 52
        base = n_rise;
        send(250, 1'b0, -1, 1'b0);
        wait_done(2000);
        chk("m250_count", n_rise - base, 3);
        chk("m250_s0", obs_steps[0], 99);
        chk("m250_s1", obs_steps[1], 99);
        chk("m250_s2", obs_steps[2], 52);
        chk("m250_r0", obs_rem[0], 151);
        chk("m250_r1", obs_rem[1], 52);
        chk("m250_r2", obs_rem[2], 0);
        chk("m250_direction", int'(bus.direction), 0);

        // zero move: busy two cycles, done in the second, no new_in
        base = n_rise;
        send(0, 1'b0, -1, 1'b0);
        chk("zero_busy1", int'(bus.busy), 1);
        chk("zero_done1", int'(bus.done), 0);
        tick();
        chk("zero_busy2", int'(bus.busy), 1);
        chk("zero_done2", int'(bus.done), 1);
        tick();
        chk("zero_busy3", int'(bus.busy), 0);
        chk("zero_done3", int'(bus.done), 0);
        chk("zero_ready3", int'(bus.cmd_ready), 1);
        chk("zero_no_new_in", n_rise - base, 0);

        // 300 with abort during the second chunk's WAIT
        base = n_rise;
        send(300, 1'b0, 2, 1'b1);
        wait_rises(base + 2, 2000);
        begin
            int t;
            t = 0;
            while (bus.new_in && t < 50) begin
                tick();
                t++;
            end
        end
        repeat (S + 3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_rem", int'(bus.steps_remaining), 0);
        chk("abort_busy", int'(bus.busy), 1);
        wait_done(2000);
        chk("abort_count", n_rise - base, 2);
        chk("abort_s1", obs_steps[1], 99);

        // stale finished held high: timing still exact, nothing skipped
        stale = 1'b1;
        bus.finished = 1'b1;
        base = n_rise;
        send(150, 1'b1, -1, 1'b0);
        wait_done(2000);
        chk("stale_count", n_rise - base, 2);
        chk("stale_s1", obs_steps[1], 51);
        stale = 1'b0;
        bus.finished = 1'b0;

        // reset mid-PULSE: new_in drops asynchronously
        base = n_rise;
        send(200, 1'b0, -1, 1'b0);
        wait_rises(base + 1, 200);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_new_in", int'(bus.new_in), 0);
        exp_q.delete();
        exp_pos = 0;
        tick();
        check_reset_values("midreset");
        reset_n = 1'b1;

        // recovery move
        send(3, 1'b0, -1, 1'b0);
        wait_done(500);
        chk("recover_steps", obs_steps[0], 3);
`ifdef STEP_CHUNKER_POSITION_TRACK_EN
        chk("recover_position", int'(bus.position), 3);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
